// File: rtl/decode_queue_stage.sv
// decode_queue_stage: fetch-to-execute decode stage.
// A DEPTH-entry FIFO of {pc, instr} feeds a combinational RV32I/Zicsr(/M)
// decoder whose result is captured in a registered micro-op with
// valid/ready handshakes. A small FSM inserts one bubble on load-use hazards.
module decode_queue_stage #(
    parameter int          DEPTH    = 4,
    parameter bit          ENABLE_M = 1'b0,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_alu_op,
    output logic [3:0]               out_access,
    output logic [2:0]               out_wb_sel,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_imm,
    output logic [11:0]              out_csr_addr,
    output logic                     out_is_jump,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3,
        ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7,
        ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_LUI = 5'd10, ALU_EQ = 5'd11,
        ALU_NE = 5'd12,  ALU_LT = 5'd13,  ALU_GE = 5'd14,  ALU_LTU = 5'd15,
        ALU_GEU = 5'd16, ALU_CSRRW = 5'd17, ALU_CSRRS = 5'd18, ALU_CSRRC = 5'd19,
        ALU_MUL = 5'd20, ALU_MULH = 5'd21, ALU_MULHSU = 5'd22, ALU_MULHU = 5'd23,
        ALU_DIV = 5'd24, ALU_DIVU = 5'd25, ALU_REM = 5'd26, ALU_REMU = 5'd27,
        ALU_ILL = 5'd31
    } alu_cmd_e;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0, MEM_LB = 4'd1, MEM_LH = 4'd2, MEM_LW = 4'd3,
        MEM_LBU = 4'd4,  MEM_LHU = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7,
        MEM_SW = 4'd8
    } mem_access_e;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0, WB_RI_TYPE_LUI = 3'd1, WB_LOAD = 3'd2,
        WB_PC4 = 3'd3,  WB_ZICSR = 3'd4
    } wb_sel_e;

    typedef enum logic {IDLE, LOAD_PEND} il_state_e;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, load_en, stall, nonempty;
    il_state_e     state, state_next;
    logic [4:0]    pend_rd, pend_rd_next;

    logic [31:0]   h_pc, h_ins;
    alu_cmd_e      d_alu;
    mem_access_e   d_acc;
    wb_sel_e       d_wb;
    logic [4:0]    d_rd, d_rs1, d_rs2;
    logic [31:0]   d_imm;
    logic          d_jump, d_ill;

    assign in_ready = (count < CW'(DEPTH));
    assign nonempty = (count != '0);
    assign push     = in_valid & in_ready & ~flush;
    assign h_pc     = mem[rd_ptr][63:32];
    assign h_ins    = mem[rd_ptr][31:0];

    // FIFO storage; entries need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_pc, in_instr};
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (load_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, load_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Combinational decode of the FIFO head entry.
    always_comb begin
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc    = h_ins[6:0];
        f3     = h_ins[14:12];
        f7     = h_ins[31:25];
        d_alu  = ALU_ADD;
        d_acc  = MEM_NONE;
        d_wb   = WB_NONE;
        d_rd   = '0;
        d_rs1  = '0;
        d_rs2  = '0;
        d_imm  = '0;
        d_jump = 1'b0;
        d_ill  = 1'b0;
        case (opc)
            7'b0110111: begin // LUI
                d_alu = ALU_LUI; d_rd = h_ins[11:7]; d_wb = WB_RI_TYPE_LUI;
                d_imm = {h_ins[31:12], 12'b0};
            end
            7'b0010111: begin // AUIPC
                d_rd = h_ins[11:7]; d_wb = WB_RI_TYPE_LUI;
                d_imm = {h_ins[31:12], 12'b0};
            end
            7'b1101111: begin // JAL
                d_rd = h_ins[11:7]; d_wb = WB_PC4; d_jump = 1'b1;
                d_imm = {{11{h_ins[31]}}, h_ins[31], h_ins[19:12], h_ins[20], h_ins[30:21], 1'b0};
            end
            7'b1100111: begin // JALR
                d_rd = h_ins[11:7]; d_rs1 = h_ins[19:15]; d_wb = WB_PC4; d_jump = 1'b1;
                d_imm = {{20{h_ins[31]}}, h_ins[31:20]};
                d_ill = (f3 != 3'b000);
            end
            7'b1100011: begin // BRANCH
                d_rs1 = h_ins[19:15]; d_rs2 = h_ins[24:20]; d_jump = 1'b1;
                d_imm = {{19{h_ins[31]}}, h_ins[31], h_ins[7], h_ins[30:25], h_ins[11:8], 1'b0};
                case (f3)
                    3'b000:  d_alu = ALU_EQ;
                    3'b001:  d_alu = ALU_NE;
                    3'b100:  d_alu = ALU_LT;
                    3'b101:  d_alu = ALU_GE;
                    3'b110:  d_alu = ALU_LTU;
                    3'b111:  d_alu = ALU_GEU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0000011: begin // LOAD
                d_rd = h_ins[11:7]; d_rs1 = h_ins[19:15]; d_wb = WB_LOAD;
                d_imm = {{20{h_ins[31]}}, h_ins[31:20]};
                case (f3)
                    3'b000:  d_acc = MEM_LB;
                    3'b001:  d_acc = MEM_LH;
                    3'b010:  d_acc = MEM_LW;
                    3'b100:  d_acc = MEM_LBU;
                    3'b101:  d_acc = MEM_LHU;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0100011: begin // STORE
                d_rs1 = h_ins[19:15]; d_rs2 = h_ins[24:20];
                d_imm = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
                case (f3)
                    3'b000:  d_acc = MEM_SB;
                    3'b001:  d_acc = MEM_SH;
                    3'b010:  d_acc = MEM_SW;
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0010011: begin // OP-IMM
                d_rd = h_ins[11:7]; d_rs1 = h_ins[19:15]; d_wb = WB_RI_TYPE_LUI;
                d_imm = {{20{h_ins[31]}}, h_ins[31:20]};
                case (f3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: begin d_alu = ALU_SLL; d_ill = (f7 != 7'b0000000); end
                    default: begin
                        if (f7 == 7'b0000000)      d_alu = ALU_SRL;
                        else if (f7 == 7'b0100000) d_alu = ALU_SRA;
                        else                       d_ill = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin // OP
                d_rd = h_ins[11:7]; d_rs1 = h_ins[19:15]; d_rs2 = h_ins[24:20];
                d_wb = WB_RI_TYPE_LUI;
                if (f7 == 7'b0000001) begin
                    if (ENABLE_M) begin
                        case (f3)
                            3'b000:  d_alu = ALU_MUL;
                            3'b001:  d_alu = ALU_MULH;
                            3'b010:  d_alu = ALU_MULHSU;
                            3'b011:  d_alu = ALU_MULHU;
                            3'b100:  d_alu = ALU_DIV;
                            3'b101:  d_alu = ALU_DIVU;
                            3'b110:  d_alu = ALU_REM;
                            default: d_alu = ALU_REMU;
                        endcase
                    end else begin
                        d_ill = 1'b1;
                    end
                end else if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_alu = ALU_ADD;
                        3'b001:  d_alu = ALU_SLL;
                        3'b010:  d_alu = ALU_SLT;
                        3'b011:  d_alu = ALU_SLTU;
                        3'b100:  d_alu = ALU_XOR;
                        3'b101:  d_alu = ALU_SRL;
                        3'b110:  d_alu = ALU_OR;
                        default: d_alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_alu = ALU_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            7'b0001111: begin // FENCE travels as a no-op
            end
            7'b1110011: begin // SYSTEM: CSR ops; ECALL/EBREAK go to execute as traps
                d_rd = h_ins[11:7]; d_wb = WB_ZICSR;
                case (f3)
                    3'b001:  begin d_alu = ALU_CSRRW; d_rs1 = h_ins[19:15]; end
                    3'b010:  begin d_alu = ALU_CSRRS; d_rs1 = h_ins[19:15]; end
                    3'b011:  begin d_alu = ALU_CSRRC; d_rs1 = h_ins[19:15]; end
                    3'b101:  begin d_alu = ALU_CSRRW; d_imm = {27'b0, h_ins[19:15]}; end
                    3'b110:  begin d_alu = ALU_CSRRS; d_imm = {27'b0, h_ins[19:15]}; end
                    3'b111:  begin d_alu = ALU_CSRRC; d_imm = {27'b0, h_ins[19:15]}; end
                    default: d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_alu  = ALU_ILL;
            d_acc  = MEM_NONE;
            d_rd   = '0;
            d_rs1  = '0;
            d_rs2  = '0;
            d_imm  = '0;
            d_jump = 1'b0;
        end
        if (d_rd == '0)
            d_wb = WB_NONE;
    end

    // Interlock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend_rd <= '0;
        end else if (flush) begin
            state   <= IDLE;
            pend_rd <= '0;
        end else begin
            state   <= state_next;
            pend_rd <= pend_rd_next;
        end
    end

    // Interlock next state, stall and output-register load enable.
    // Stall only while the load still occupies the output register; the
    // cycle after it leaves is the bubble, so the dependent op loads then.
    always_comb begin
        logic dep;
        state_next   = state;
        pend_rd_next = pend_rd;
        dep   = ((d_rs1 != '0) && (d_rs1 == pend_rd)) ||
                ((d_rs2 != '0) && (d_rs2 == pend_rd));
        stall = (state == LOAD_PEND) && out_valid && dep;
        load_en = (~out_valid | out_ready) & nonempty & ~stall & ~flush;
        case (state)
            IDLE: begin
                if (load_en && d_wb == WB_LOAD) begin
                    state_next   = LOAD_PEND;
                    pend_rd_next = d_rd;
                end
            end
            default: begin
                if (load_en) begin
                    if (d_wb == WB_LOAD) begin
                        pend_rd_next = d_rd;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!out_valid) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Registered micro-op; holds while out_valid & !out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC;
            out_alu_op   <= '0;
            out_access   <= MEM_NONE;
            out_wb_sel   <= WB_NONE;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_imm      <= '0;
            out_csr_addr <= '0;
            out_is_jump  <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid    <= 1'b1;
            out_pc       <= h_pc;
            out_alu_op   <= d_alu;
            out_access   <= d_acc;
            out_wb_sel   <= d_wb;
            out_rd       <= d_rd;
            out_rs1      <= d_rs1;
            out_rs2      <= d_rs2;
            out_imm      <= d_imm;
            out_csr_addr <= h_ins[31:20];
            out_is_jump  <= d_jump;
            out_illegal  <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed testbench for decode_queue_stage: one DUT without M, one with M,
// both driven by the same stimulus.
module tb_decode_queue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid, out_is_jump, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_alu_op, out_rd, out_rs1, out_rs2;
    logic [3:0]  out_access;
    logic [2:0]  out_wb_sel;
    logic [11:0] out_csr_addr;
    logic [2:0]  count;

    logic        m_in_ready, m_out_valid, m_out_is_jump, m_out_illegal;
    logic [31:0] m_out_pc, m_out_imm;
    logic [4:0]  m_out_alu_op, m_out_rd, m_out_rs1, m_out_rs2;
    logic [3:0]  m_out_access;
    logic [2:0]  m_out_wb_sel;
    logic [11:0] m_out_csr_addr;
    logic [2:0]  m_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RPC = 32'h0000_1000;

    always #5 clk = ~clk;

    decode_queue_stage #(.DEPTH(4), .ENABLE_M(1'b0), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_op(out_alu_op), .out_access(out_access),
        .out_wb_sel(out_wb_sel), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_csr_addr(out_csr_addr), .out_is_jump(out_is_jump),
        .out_illegal(out_illegal), .count(count)
    );

    decode_queue_stage #(.DEPTH(4), .ENABLE_M(1'b1), .RESET_PC(RPC)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .out_alu_op(m_out_alu_op), .out_access(m_out_access),
        .out_wb_sel(m_out_wb_sel), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_imm(m_out_imm), .out_csr_addr(m_out_csr_addr), .out_is_jump(m_out_is_jump),
        .out_illegal(m_out_illegal), .count(m_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        step(); step();

        // Reset state
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out_pc", out_pc, RPC);
        check("rst count", {29'b0, count}, 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst wb_sel", {29'b0, out_wb_sel}, 32'd0);
        check("rst access", {28'b0, out_access}, 32'd0);
        rst = 1'b0;
        step();

        // 1: ADDI x1,x0,5 @0x100, two-cycle latency
        offer(32'h100, 32'h0050_0093);
        step();
        in_valid = 1'b0;
        check("t1 count after push", {29'b0, count}, 32'd1);
        check("t1 no same-cycle decode", {31'b0, out_valid}, 32'd0);
        step();
        check("t1 out_valid", {31'b0, out_valid}, 32'd1);
        check("t1 pc", out_pc, 32'h100);
        check("t1 alu", {27'b0, out_alu_op}, 32'd0);
        check("t1 imm", out_imm, 32'd5);
        check("t1 rd", {27'b0, out_rd}, 32'd1);
        check("t1 rs2", {27'b0, out_rs2}, 32'd0);
        check("t1 wb", {29'b0, out_wb_sel}, 32'd1);
        check("t1 count", {29'b0, count}, 32'd0);
        out_ready = 1'b1;
        step();
        check("t1 consumed", {31'b0, out_valid}, 32'd0);

        // 2: stalled output, fill FIFO, in_ready drops, order preserved
        out_ready = 1'b0;
        begin
            logic [2:0] exp_cnt [5];
            logic       exp_rdy [5];
            exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
            exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int k = 1; k <= 5; k++) begin
                offer(32'h200 + 32'(k * 4), 32'h0000_0093 | (32'(k) << 20));
                step();
                check("t2 fill count", {29'b0, count}, {29'b0, exp_cnt[k-1]});
                check("t2 in_ready", {31'b0, in_ready}, {31'b0, exp_rdy[k-1]});
                if (k >= 2) check("t2 held imm", out_imm, 32'd1);
            end
        end
        offer(32'h218, 32'h0060_0093);
        step();
        check("t2 full rejects count", {29'b0, count}, 32'd4);
        check("t2 held pc", out_pc, 32'h204);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t2 drain imm", out_imm, 32'(k));
            check("t2 drain valid", {31'b0, out_valid}, 32'd1);
        end
        step();
        check("t2 drained", {31'b0, out_valid}, 32'd0);
        check("t2 drained count", {29'b0, count}, 32'd0);

        // 3a: LW x5,0(x2) then dependent ADD x6,x5,x1 -> one bubble
        offer(32'h300, 32'h0001_2283);
        step();
        offer(32'h304, 32'h0012_8333);
        step();
        in_valid = 1'b0;
        check("t3 lw valid", {31'b0, out_valid}, 32'd1);
        check("t3 lw access", {28'b0, out_access}, 32'd3);
        check("t3 lw wb", {29'b0, out_wb_sel}, 32'd2);
        check("t3 lw rd", {27'b0, out_rd}, 32'd5);
        step();
        check("t3 bubble", {31'b0, out_valid}, 32'd0);
        check("t3 bubble count", {29'b0, count}, 32'd1);
        step();
        check("t3 add valid", {31'b0, out_valid}, 32'd1);
        check("t3 add rd", {27'b0, out_rd}, 32'd6);
        check("t3 add rs1", {27'b0, out_rs1}, 32'd5);
        check("t3 add rs2", {27'b0, out_rs2}, 32'd1);
        step();
        check("t3 add consumed", {31'b0, out_valid}, 32'd0);

        // 3b: LW then non-dependent ADD x7,x3,x4 -> no bubble
        offer(32'h310, 32'h0001_2283);
        step();
        offer(32'h314, 32'h0041_83B3);
        step();
        in_valid = 1'b0;
        check("t3b lw rd", {27'b0, out_rd}, 32'd5);
        step();
        check("t3b no bubble", {31'b0, out_valid}, 32'd1);
        check("t3b add rd", {27'b0, out_rd}, 32'd7);
        step();
        check("t3b consumed", {31'b0, out_valid}, 32'd0);

        // 4: half-full FIFO plus flush with in_valid=1
        out_ready = 1'b0;
        offer(32'h400, 32'h0010_0093); step();
        offer(32'h404, 32'h0020_0093); step();
        offer(32'h408, 32'h0030_0093); step();
        check("t4 half full", {29'b0, count}, 32'd2);
        flush = 1'b1;
        offer(32'h40C, 32'h0070_0093);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4 flush count", {29'b0, count}, 32'd0);
        check("t4 flush valid", {31'b0, out_valid}, 32'd0);
        step();
        check("t4 flush instr lost", {29'b0, count}, 32'd0);
        check("t4 still empty", {31'b0, out_valid}, 32'd0);
        offer(32'h410, 32'h0090_0093);
        step();
        in_valid = 1'b0;
        step();
        check("t4 post-flush valid", {31'b0, out_valid}, 32'd1);
        check("t4 post-flush imm", out_imm, 32'd9);
        check("t4 post-flush pc", out_pc, 32'h410);
        out_ready = 1'b1;
        step();

        // 5: MUL x3,x1,x2 with and without M
        offer(32'h500, 32'h0220_81B3);
        step();
        in_valid = 1'b0;
        step();
        check("t5 noM valid", {31'b0, out_valid}, 32'd1);
        check("t5 noM illegal", {31'b0, out_illegal}, 32'd1);
        check("t5 noM alu", {27'b0, out_alu_op}, 32'd31);
        check("t5 noM rd", {27'b0, out_rd}, 32'd0);
        check("t5 noM wb", {29'b0, out_wb_sel}, 32'd0);
        check("t5 M illegal", {31'b0, m_out_illegal}, 32'd0);
        check("t5 M alu", {27'b0, m_out_alu_op}, 32'd20);
        check("t5 M rd", {27'b0, m_out_rd}, 32'd3);
        step();

        // 6: CSRRSI x4,mstatus,0x1F; BEQ back -8; unknown opcode
        offer(32'h600, 32'h300F_E273);
        step();
        offer(32'h604, 32'hFE00_0CE3);
        step();
        offer(32'h608, 32'hFFFF_FFFF);
        check("t6 csr imm", out_imm, 32'h0000_001F);
        check("t6 csr addr", {20'b0, out_csr_addr}, 32'h300);
        check("t6 csr wb", {29'b0, out_wb_sel}, 32'd4);
        check("t6 csr alu", {27'b0, out_alu_op}, 32'd18);
        check("t6 csr rd", {27'b0, out_rd}, 32'd4);
        check("t6 csr rs1", {27'b0, out_rs1}, 32'd0);
        step();
        in_valid = 1'b0;
        check("t6 beq imm", out_imm, 32'hFFFF_FFF8);
        check("t6 beq jump", {31'b0, out_is_jump}, 32'd1);
        check("t6 beq alu", {27'b0, out_alu_op}, 32'd11);
        check("t6 beq wb", {29'b0, out_wb_sel}, 32'd0);
        step();
        check("t6 unk illegal", {31'b0, out_illegal}, 32'd1);
        check("t6 unk rd", {27'b0, out_rd}, 32'd0);
        check("t6 unk jump", {31'b0, out_is_jump}, 32'd0);
        step();

        // 7: asynchronous reset mid-transfer discards everything
        out_ready = 1'b0;
        offer(32'h700, 32'h0010_0093); step();
        offer(32'h704, 32'h0020_0093); step();
        in_valid = 1'b0;
        check("t7 loaded", {31'b0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7 async count", {29'b0, count}, 32'd0);
        check("t7 async valid", {31'b0, out_valid}, 32'd0);
        check("t7 async pc", out_pc, RPC);
        rst = 1'b0;
        out_ready = 1'b1;
        step(); step();
        check("t7 no partial op", {31'b0, out_valid}, 32'd0);
        check("t7 empty", {29'b0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
